// File: rtl/cnn_window_gen.sv
// cnn_window_gen: loads one raster-ordered image into an internal frame buffer,
// then streams every KxK window with its output coordinates.
// Optional zero padding ("same" convolution) is enabled by defining CNN_WIN_PAD_EN.
//
// Handshakes: a transfer happens on a rising CLK edge where the source holds
// VALID high and the sink holds READY high; the source keeps its payload stable
// while VALID is high and READY is low, and never drops VALID before the transfer.
module cnn_window_gen #(
  parameter int PIX_W   = 8,
  parameter int IMG_H   = 28,
  parameter int IMG_W   = 28,
  parameter int K       = 5,
  parameter int STRIDE  = 1,
  parameter int COORD_W = 5
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   START,
  input  logic [PIX_W-1:0]       PIX_IN,
  input  logic                   PIX_VALID,
  output logic                   PIX_READY,
  output logic [K*K*PIX_W-1:0]   WIN_OUT,
  output logic [COORD_W-1:0]     WIN_X,
  output logic [COORD_W-1:0]     WIN_Y,
  output logic                   WIN_VALID,
  input  logic                   WIN_READY,
  output logic                   WIN_LAST,
  output logic                   BUSY,
  output logic                   FRAME_DONE,
  output logic [1:0]             DBG_STATE
);

`ifdef CNN_WIN_PAD_EN
  localparam int P = (K - 1) / 2;
`else
  localparam int P = 0;
`endif
  localparam int NPOS_Y = (IMG_H + 2 * P - K) / STRIDE + 1;
  localparam int NPOS_X = (IMG_W + 2 * P - K) / STRIDE + 1;
  localparam int NPIX   = IMG_H * IMG_W;
  localparam int AW     = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int WIN_W  = K * K * PIX_W;

  // S_SETTLE is the one cycle between the last pixel write and the first
  // window capture, so the final pixel is visible in the buffer.
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SETTLE, S_SCAN} state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [COORD_W-1:0] cx_q, cx_d;          // row index of next window to present
  logic [COORD_W-1:0] cy_q, cy_d;          // column index of next window to present
  logic               pix_ready_q, pix_ready_d;
  logic               win_valid_q, win_valid_d;
  logic               win_last_q, win_last_d;
  logic               frame_done_q, frame_done_d;
  logic [COORD_W-1:0] win_x_q, win_x_d;
  logic [COORD_W-1:0] win_y_q, win_y_d;
  logic [WIN_W-1:0]   win_out_q, win_out_d;

  logic [PIX_W-1:0]   mem_q [NPIX];
  logic               mem_we;
  logic [WIN_W-1:0]   win_next;
  logic [AW-1:0]      rd_addr;
  int                 row;
  int                 col;
  logic               pos_last;

  // Frame buffer write port; contents are intentionally not reset.
  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[addr_q] <= PIX_IN;
  end

  // Gather the KxK window at (cx_q, cy_q); out-of-image taps read as zero.
  always_comb begin
    win_next = '0;
    row      = 0;
    col      = 0;
    rd_addr  = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        row = int'(cx_q) * STRIDE + i - P;
        col = int'(cy_q) * STRIDE + j - P;
        if (row >= 0 && row < IMG_H && col >= 0 && col < IMG_W) begin
          rd_addr = AW'(row * IMG_W + col);
          win_next[(i*K+j)*PIX_W +: PIX_W] = mem_q[rd_addr];
        end
      end
    end
  end

  assign pos_last = (cx_q == COORD_W'(NPOS_Y - 1)) && (cy_q == COORD_W'(NPOS_X - 1));

  // Next-state and output register logic for the load/scan controller.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    pix_ready_d  = pix_ready_q;
    win_valid_d  = win_valid_q;
    win_last_d   = win_last_q;
    frame_done_d = 1'b0;
    win_x_d      = win_x_q;
    win_y_d      = win_y_q;
    win_out_d    = win_out_q;
    mem_we       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d     = S_LOAD;
          pix_ready_d = 1'b1;
          addr_d      = '0;
        end
      end
      S_LOAD: begin
        if (PIX_VALID && pix_ready_q) begin
          mem_we = 1'b1;
          if (addr_q == AW'(NPIX - 1)) begin
            pix_ready_d = 1'b0;
            state_d     = S_SETTLE;
          end else begin
            addr_d = addr_q + AW'(1);
          end
        end
      end
      S_SETTLE: begin
        state_d = S_SCAN;
        cx_d    = '0;
        cy_d    = '0;
      end
      default: begin
        if (!win_valid_q || WIN_READY) begin
          if (win_valid_q && win_last_q) begin
            state_d      = S_IDLE;
            win_valid_d  = 1'b0;
            win_last_d   = 1'b0;
            frame_done_d = 1'b1;
          end else begin
            win_out_d   = win_next;
            win_x_d     = cx_q;
            win_y_d     = cy_q;
            win_last_d  = pos_last;
            win_valid_d = 1'b1;
            if (cy_q == COORD_W'(NPOS_X - 1)) begin
              cy_d = '0;
              cx_d = cx_q + COORD_W'(1);
            end else begin
              cy_d = cy_q + COORD_W'(1);
            end
          end
        end
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      pix_ready_q  <= 1'b0;
      win_valid_q  <= 1'b0;
      win_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      win_x_q      <= '0;
      win_y_q      <= '0;
      win_out_q    <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      pix_ready_q  <= pix_ready_d;
      win_valid_q  <= win_valid_d;
      win_last_q   <= win_last_d;
      frame_done_q <= frame_done_d;
      win_x_q      <= win_x_d;
      win_y_q      <= win_y_d;
      win_out_q    <= win_out_d;
    end
  end

  assign PIX_READY  = pix_ready_q;
  assign WIN_OUT    = win_out_q;
  assign WIN_X      = win_x_q;
  assign WIN_Y      = win_y_q;
  assign WIN_VALID  = win_valid_q;
  assign WIN_LAST   = win_last_q;
  assign FRAME_DONE = frame_done_q;
  assign BUSY       = (state_q != S_IDLE);
  assign DBG_STATE  = state_q;

endmodule
